arith_rs: RTL and testbench
===========================

ARITH_RS -- requirements
Module: arith_rs

Interface
REQ-001 Parameter DEPTH, default 4, number of reservation-station entries; power of two, at least 2.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 dispatch_valid  input  1  dispatch offers an instruction this cycle.
REQ-005 dispatch_pkt  input  rs_t  offered entry: alu_op, rd_paddr, rd_valid, rob_addr, rs1/rs2_paddr, rs1/rs2_ready, rs1/rs2_data.
REQ-006 rs_full  output  1  high when no free entry; dispatch shall not be accepted.
REQ-007 cdb_in  input  cdb_t  completion broadcast (valid, rd_paddr, rd_data, rd_valid) used for operand wakeup.
REQ-008 flush  input  1  mispredict recovery; discards all entries.
REQ-009 arith_ready  input  1  downstream ALU unit can take an instruction this cycle.
REQ-010 issue_valid  output  1  arith_next holds an issuable instruction.
REQ-011 arith_next  output  rs_t  instruction offered to the ALU unit.

Function
REQ-012 Each entry holds an rs_t payload plus a valid bit and a dispatch-order age; no other state is needed.
REQ-013 Accept: dispatch_valid && !rs_full && !flush; the packet is written to the lowest-index free entry at the next edge, valid set.
REQ-014 rs_full = all valid bits set, from registered state only; an issue in the same cycle does not lower rs_full, so no dispatch is taken into a full station.
REQ-015 Wakeup: when cdb_in.valid && cdb_in.rd_valid && cdb_in.rd_paddr != 0, every valid entry with rsX_ready=0 and rsX_paddr == cdb_in.rd_paddr shall capture rd_data into rsX_data and set rsX_ready at the next edge; rs1 and rs2 are checked independently.
REQ-016 Dispatch bypass: a packet accepted in the same cycle as a matching broadcast is stored already woken with the broadcast data.
REQ-017 Physical register 0 is never woken; dispatch delivers p0 sources with ready=1.
REQ-018 Ready entry: valid && rs1_ready && rs2_ready, from registered state only; a same-cycle wakeup makes an entry issuable no earlier than the next cycle.
REQ-019 Select: the oldest ready entry by dispatch order; ties are impossible.
REQ-020 issue_valid = any ready entry && !flush; arith_next = selected entry payload, '0 when issue_valid=0.
REQ-021 Issue handshake: issue_valid && arith_ready frees the selected entry at the next edge; if arith_ready=0, the station keeps offering the same oldest ready entry unless an older one becomes ready.
REQ-022 Same-cycle issue and dispatch are both honoured; the freed slot is reusable from the following cycle.
REQ-023 Age: dispatch order is preserved across arbitrary free/allocate patterns, including wrap-around of any age counter; a stamp wider than log2(DEPTH)+1 bits or an age matrix is acceptable.
REQ-024 Flush: all valid bits clear at the next edge; the same-cycle dispatch is dropped, no issue happens, and rs_full is 0 the following cycle.
REQ-025 Latency: dispatch with both operands ready gives issue_valid one cycle after acceptance; wakeup-to-issue is one cycle.

Reset
REQ-026 While rst is high, all valid bits and ages clear asynchronously: issue_valid=0, rs_full=0, arith_next='0.
REQ-027 An assertion of rst mid-operation discards all entries; no instruction issues until a new dispatch after reset is released.

Verification
REQ-028 Ready dispatch: DEPTH=4, dispatch add, both sources ready, arith_ready=1 -> issue_valid=1 next cycle with matching rob_addr; entry freed; issue_valid=0 the cycle after.
REQ-029 Wakeup: dispatch with rs1_paddr=5 not ready; cdb_in broadcast {valid=1, rd_paddr=5, rd_data=32'hDEAD_BEEF} two cycles later -> issue_valid one cycle after the broadcast, arith_next.rs1_data=32'hDEAD_BEEF; a broadcast to paddr 0 wakes nothing.
REQ-030 Fill/backpressure: 4 dispatches, arith_ready=0 -> rs_full=1 and a 5th dispatch is ignored; raising arith_ready drains in dispatch order (oldest rob_addr first), rs_full=0 one cycle after the first issue.
REQ-031 Ordering: entries A (older, not ready) and B (ready); wake A -> B issues first, then A.
REQ-032 Bypass and flush: dispatch in the same cycle as a matching broadcast -> stored ready; flush with 3 valid entries plus a dispatch -> issue_valid=0 and rs_full=0, with no further issues.
REQ-033 Async reset: assert rst between clock edges with entries valid -> issue_valid and rs_full drop immediately, before the next edge.

Source files
------------

// File: rtl/arith_rs.sv
// Arithmetic reservation station: holds dispatched ALU ops, wakes operands from
// the CDB and issues the oldest ready entry to the ALU.
package arith_rs_pkg;
  typedef struct packed {
    logic [3:0]  alu_op;
    logic [5:0]  rd_paddr;
    logic        rd_valid;
    logic [4:0]  rob_addr;
    logic [5:0]  rs1_paddr;
    logic [5:0]  rs2_paddr;
    logic        rs1_ready;
    logic        rs2_ready;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
  } rs_t;

  typedef struct packed {
    logic        valid;
    logic [5:0]  rd_paddr;
    logic [31:0] rd_data;
    logic        rd_valid;
  } cdb_t;

  // p0 is hardwired, so a broadcast to it never wakes anything
  function automatic rs_t wake(input rs_t e, input cdb_t c);
    rs_t r;
    r = e;
    if (c.valid && c.rd_valid && (c.rd_paddr != '0)) begin
      if (!e.rs1_ready && (e.rs1_paddr == c.rd_paddr)) begin
        r.rs1_ready = 1'b1;
        r.rs1_data  = c.rd_data;
      end
      if (!e.rs2_ready && (e.rs2_paddr == c.rd_paddr)) begin
        r.rs2_ready = 1'b1;
        r.rs2_data  = c.rd_data;
      end
    end
    return r;
  endfunction
endpackage

module arith_rs
  import arith_rs_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic dispatch_valid,
  input  rs_t  dispatch_pkt,
  output logic rs_full,
  input  cdb_t cdb_in,
  input  logic flush,
  input  logic arith_ready,
  output logic issue_valid,
  output rs_t  arith_next
);
  localparam int IW = $clog2(DEPTH);

  rs_t              r_ent   [DEPTH];
  logic [DEPTH-1:0] r_valid;
  // r_older[i][j] set means entry i was dispatched before entry j
  logic [DEPTH-1:0] r_older [DEPTH];

  logic [DEPTH-1:0] w_rdy;
  logic [DEPTH-1:0] w_sel;
  logic [IW-1:0]    w_alloc_idx;
  logic             w_accept;
  logic             w_issue;

  always_comb begin
    w_rdy = '0;
    for (int i = 0; i < DEPTH; i++)
      w_rdy[i] = r_valid[i] && r_ent[i].rs1_ready && r_ent[i].rs2_ready;
  end

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_sel[i] = w_rdy[i];
      for (int j = 0; j < DEPTH; j++)
        if ((j != i) && w_rdy[j] && r_older[j][i]) w_sel[i] = 1'b0;
    end
  end

  always_comb begin
    w_alloc_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!r_valid[i]) w_alloc_idx = IW'(i);
  end

  assign rs_full     = &r_valid;
  assign w_accept    = dispatch_valid && !rs_full && !flush;
  assign issue_valid = (|w_rdy) && !flush;
  assign w_issue     = issue_valid && arith_ready;

  always_comb begin
    arith_next = '0;
    if (issue_valid)
      for (int i = 0; i < DEPTH; i++)
        if (w_sel[i]) arith_next = r_ent[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) r_older[i] <= '0;
    end else if (flush) begin
      r_valid <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (w_issue && w_sel[i]) r_valid[i] <= 1'b0;
      if (w_accept) begin
        r_valid[w_alloc_idx] <= 1'b1;
        for (int j = 0; j < DEPTH; j++) begin
          if (j != int'(w_alloc_idx)) begin
            r_older[w_alloc_idx][j] <= 1'b0;
            r_older[j][w_alloc_idx] <= 1'b1;
          end
        end
      end
    end
  end

  // Payload needs no reset: it is only observed through a valid bit
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_accept && (w_alloc_idx == IW'(i))) r_ent[i] <= wake(dispatch_pkt, cdb_in);
      else                                       r_ent[i] <= wake(r_ent[i], cdb_in);
    end
  end
endmodule

// File: tb/tb_arith_rs.sv
// Directed bench for arith_rs; issued instructions are checked in order
// against a queue of expected {rob_addr, rs1_data}.
module tb_arith_rs;
  import arith_rs_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic dispatch_valid;
  rs_t  dispatch_pkt;
  logic rs_full;
  cdb_t cdb_in;
  logic flush;
  logic arith_ready;
  logic issue_valid;
  rs_t  arith_next;

  int n_vec = 0;
  int n_err = 0;
  logic [36:0] exp_q[$];

  arith_rs #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .dispatch_valid(dispatch_valid), .dispatch_pkt(dispatch_pkt),
    .rs_full(rs_full), .cdb_in(cdb_in), .flush(flush), .arith_ready(arith_ready),
    .issue_valid(issue_valid), .arith_next(arith_next)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: any handshake pops the next expected issue
  initial begin
    logic [36:0] e;
    forever begin
      @(negedge clk);
      if (issue_valid && arith_ready && !rst) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_issue: got rob %0d expected none", arith_next.rob_addr);
        end else begin
          e = exp_q.pop_front();
          chk("issue_rob", 32'(arith_next.rob_addr), 32'(e[36:32]));
          chk("issue_rs1_data", arith_next.rs1_data, e[31:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic rs_t mk(input logic [4:0] rob, input logic [5:0] p1, input logic r1,
                             input logic [5:0] p2, input logic r2, input logic [31:0] d1);
    rs_t p;
    p = '0;
    p.alu_op    = 4'h1;
    p.rd_paddr  = 6'd33;
    p.rd_valid  = 1'b1;
    p.rob_addr  = rob;
    p.rs1_paddr = p1;
    p.rs1_ready = r1;
    p.rs2_paddr = p2;
    p.rs2_ready = r2;
    p.rs1_data  = d1;
    p.rs2_data  = 32'h100 + 32'(rob);
    return p;
  endfunction

  task automatic disp(input rs_t p);
    dispatch_valid = 1'b1;
    dispatch_pkt   = p;
    step();
    dispatch_valid = 1'b0;
    dispatch_pkt   = '0;
  endtask

  task automatic bcast(input logic [5:0] pa, input logic [31:0] d);
    cdb_in = '{valid: 1'b1, rd_paddr: pa, rd_data: d, rd_valid: 1'b1};
    step();
    cdb_in = '0;
  endtask

  initial begin
    rst = 1'b1; dispatch_valid = 1'b0; dispatch_pkt = '0; cdb_in = '0;
    flush = 1'b0; arith_ready = 1'b0;
    #12;
    chk("rst_issue_valid", 32'(issue_valid), 0);
    chk("rst_rs_full", 32'(rs_full), 0);
    chk("rst_arith_next_zero", 32'(arith_next == '0), 1);
    rst = 1'b0;
    step();

    // Ready dispatch issues one cycle after acceptance
    arith_ready = 1'b1;
    exp_q.push_back({5'd1, 32'h11});
    disp(mk(5'd1, 6'd3, 1'b1, 6'd4, 1'b1, 32'h11));
    chk("ready_issue_valid", 32'(issue_valid), 1);
    chk("ready_rob", 32'(arith_next.rob_addr), 1);
    step();
    chk("ready_freed", 32'(issue_valid), 0);

    // Wakeup; p0 broadcast wakes nothing
    disp(mk(5'd2, 6'd5, 1'b0, 6'd4, 1'b1, 32'h0));
    chk("wait_not_ready", 32'(issue_valid), 0);
    disp(mk(5'd3, 6'd0, 1'b0, 6'd4, 1'b1, 32'h0));
    bcast(6'd0, 32'h0BAD_0000);
    chk("p0_no_wake", 32'(issue_valid), 0);
    exp_q.push_back({5'd2, 32'hDEAD_BEEF});
    bcast(6'd5, 32'hDEAD_BEEF);
    chk("wake_issue_valid", 32'(issue_valid), 1);
    chk("wake_rs1_data", arith_next.rs1_data, 32'hDEAD_BEEF);
    step();
    chk("p0_entry_stuck", 32'(issue_valid), 0);
    flush = 1'b1;
    step();
    flush = 1'b0;

    // Fill, backpressure, drain in order
    arith_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back({5'(4 + k), 32'h40 + 32'(k)});
      disp(mk(5'(4 + k), 6'd1, 1'b1, 6'd2, 1'b1, 32'h40 + 32'(k)));
    end
    chk("fill_rs_full", 32'(rs_full), 1);
    disp(mk(5'd8, 6'd1, 1'b1, 6'd2, 1'b1, 32'h48));
    chk("full_5th_ignored", 32'(rs_full), 1);
    arith_ready = 1'b1;
    step();
    chk("full_drops_after_issue", 32'(rs_full), 0);
    step(); step(); step();
    chk("drain_empty", 32'(issue_valid), 0);

    // Freed low slot reused by a younger entry
    arith_ready = 1'b0;
    disp(mk(5'd20, 6'd1, 1'b1, 6'd2, 1'b1, 32'h20));
    disp(mk(5'd21, 6'd1, 1'b1, 6'd2, 1'b1, 32'h21));
    disp(mk(5'd22, 6'd1, 1'b1, 6'd2, 1'b1, 32'h22));
    exp_q.push_back({5'd20, 32'h20});
    arith_ready = 1'b1;
    step();
    arith_ready = 1'b0;
    disp(mk(5'd23, 6'd1, 1'b1, 6'd2, 1'b1, 32'h23));
    exp_q.push_back({5'd21, 32'h21});
    exp_q.push_back({5'd22, 32'h22});
    exp_q.push_back({5'd23, 32'h23});
    arith_ready = 1'b1;
    step(); step(); step();
    chk("reuse_empty", 32'(issue_valid), 0);

    // Older A waits on p9, younger ready B goes first
    exp_q.push_back({5'd11, 32'hB0});
    exp_q.push_back({5'd10, 32'hA0});
    disp(mk(5'd10, 6'd1, 1'b1, 6'd9, 1'b0, 32'hA0));
    chk("a_not_ready", 32'(issue_valid), 0);
    disp(mk(5'd11, 6'd1, 1'b1, 6'd2, 1'b1, 32'hB0));
    bcast(6'd9, 32'h99);
    chk("a_woken", 32'(issue_valid), 1);
    step();
    chk("order_empty", 32'(issue_valid), 0);

    // Dispatch bypass, then flush with a same-cycle dispatch
    arith_ready = 1'b0;
    cdb_in = '{valid: 1'b1, rd_paddr: 6'd7, rd_data: 32'h1234, rd_valid: 1'b1};
    disp(mk(5'd30, 6'd7, 1'b0, 6'd2, 1'b1, 32'h0));
    cdb_in = '0;
    chk("bypass_issue_valid", 32'(issue_valid), 1);
    chk("bypass_rob", 32'(arith_next.rob_addr), 30);
    chk("bypass_rs1_data", arith_next.rs1_data, 32'h1234);
    disp(mk(5'd31, 6'd1, 1'b1, 6'd2, 1'b1, 32'h31));
    disp(mk(5'd32, 6'd1, 1'b1, 6'd2, 1'b1, 32'h32));
    chk("three_not_full", 32'(rs_full), 0);
    flush = 1'b1;
    arith_ready = 1'b1;
    dispatch_valid = 1'b1;
    dispatch_pkt = mk(5'd33, 6'd1, 1'b1, 6'd2, 1'b1, 32'h33);
    #1;
    chk("flush_no_issue", 32'(issue_valid), 0);
    step();
    flush = 1'b0;
    dispatch_valid = 1'b0;
    dispatch_pkt = '0;
    chk("flush_rs_full", 32'(rs_full), 0);
    chk("flush_issue_valid", 32'(issue_valid), 0);
    step();
    chk("flush_stays_empty", 32'(issue_valid), 0);

    // Async reset between edges
    arith_ready = 1'b0;
    for (int k = 0; k < 4; k++) disp(mk(5'(24 + k), 6'd1, 1'b1, 6'd2, 1'b1, 32'h0));
    chk("pre_rst_full", 32'(rs_full), 1);
    chk("pre_rst_issue_valid", 32'(issue_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_issue_valid", 32'(issue_valid), 0);
    chk("async_rst_rs_full", 32'(rs_full), 0);
    chk("async_rst_next_zero", 32'(arith_next == '0), 1);
    rst = 1'b0;
    step();
    arith_ready = 1'b1;
    step();
    chk("post_rst_idle", 32'(issue_valid), 0);
    exp_q.push_back({5'd28, 32'h28});
    disp(mk(5'd28, 6'd1, 1'b1, 6'd2, 1'b1, 32'h28));
    chk("post_rst_dispatch", 32'(issue_valid), 1);
    step();
    arith_ready = 1'b0;
    step();

    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
